bin2rns_seq_conv: RTL and testbench

//  Iterative multi-channel binary-to-RNS forward converter with runtime moduli, signed/unsigned mode and valid/ready handshakes.

---
 rtl/rns_pkg.sv | 45 ++++
 rtl/rns_mod_step.sv | 39 +++
 rtl/bin2rns_seq_conv.sv | 148 ++++++++++++++
 tb/tb_bin2rns_seq_conv.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rns_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rns_pkg
//  Description : Shared definitions for the binary-to-RNS sequential
//                converter. Holds the FSM state encoding, a ceiling-log2
//                helper, the default step count and a residue-negate helper.
//  Revision    : 1.0  initial release
// ============================================================================
package rns_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int C_DEF_WIDTH = 32;
    localparam int C_DEF_CHUNK = 4;
    localparam int C_DEF_STEPS = C_DEF_WIDTH / C_DEF_CHUNK;

    // Width of the residue-negate helper; moduli are at most this wide.
    localparam int C_NEG_W = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

    // Number of Horner steps needed to fold a WIDTH-bit operand.
    function automatic int steps(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Additive inverse of residue r modulo m: 0 stays 0, otherwise m - r.
    function automatic logic [C_NEG_W-1:0] res_neg(input logic [C_NEG_W-1:0] m,
                                                   input logic [C_NEG_W-1:0] r);
        return (r == '0) ? '0 : (m - r);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rns_mod_step.sv
`default_nettype none
// ============================================================================
//  Module      : rns_mod_step
//  Description : Combinational single-channel Horner step for the RNS
//                converter: res = ({r, chunk}) mod m, computed with CHUNK
//                restoring subtractions of m<<k (k = CHUNK-1..0).
//  Ports       : r     - current residue (must be < m)
//                chunk - next CHUNK operand bits
//                m     - modulus (2..2**MOD_W-1 for a meaningful result)
//                res   - updated residue
//  Revision    : 1.0  initial release
// ============================================================================
module rns_mod_step #(
    parameter int MOD_W = 4,
    parameter int CHUNK = 4
) (
    input  logic [MOD_W-1:0] r,
    input  logic [CHUNK-1:0] chunk,
    input  logic [MOD_W-1:0] m,
    output logic [MOD_W-1:0] res
);

    logic [MOD_W+CHUNK-1:0] w_t;
    logic [MOD_W+CHUNK-1:0] w_sub;

    // Since r < m, {r,chunk} < m * 2**CHUNK, so CHUNK conditional
    // subtractions of decreasing multiples leave a value below m.
    always_comb begin
        w_t   = {r, chunk};
        w_sub = '0;
        for (int k = CHUNK - 1; k >= 0; k--) begin
            w_sub = {{CHUNK{1'b0}}, m} << k;
            if (w_t >= w_sub) w_t = w_t - w_sub;
        end
        res = w_t[MOD_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/bin2rns_seq_conv.sv
`default_nettype none
// ============================================================================
//  Module      : bin2rns_seq_conv
//  Description : Iterative multi-channel binary-to-RNS forward converter.
//                Folds the operand magnitude CHUNK bits per cycle, MSB first,
//                on NCH channels with runtime moduli; signed operands are
//                converted via magnitude and a final residue negation.
//  Ports       : clk, reset (async, active-high)
//                in_valid/in_ready/in_data/in_signed/moduli - operand side
//                out_valid/out_ready/out_res/out_err        - result side
//  Revision    : 1.0  initial release
// ============================================================================
module bin2rns_seq_conv
    import rns_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int MOD_W = 4,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_signed,
    input  logic [NCH*MOD_W-1:0] moduli,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH*MOD_W-1:0] out_res,
    output logic [NCH-1:0]       out_err
);

    localparam int C_STEPS = steps(WIDTH, CHUNK);
    localparam int C_CNT_W = (C_STEPS > 1) ? clog2(C_STEPS) : 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_mag;
    logic                 r_neg;
    logic [NCH*MOD_W-1:0] r_mod;
    logic [NCH*MOD_W-1:0] r_acc;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [NCH*MOD_W-1:0] r_res;
    logic [NCH-1:0]       r_err;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_neg_in;
    logic [WIDTH-1:0]     w_mag_in;
    logic [NCH*MOD_W-1:0] w_step_all;
    logic [NCH*MOD_W-1:0] w_fin_all;
    logic [NCH-1:0]       w_err;

    assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
    assign w_accept  = in_valid & in_ready;
    assign w_last    = (r_state == S_BUSY) && (r_cnt == C_CNT_W'(C_STEPS - 1));
    assign out_valid = (r_state == S_DONE);
    assign out_res   = r_res;
    assign out_err   = r_err;

    // Most negative input negates to itself, which read unsigned is 2**(WIDTH-1).
    assign w_neg_in = in_signed & in_data[WIDTH-1];
    assign w_mag_in = w_neg_in ? -in_data : in_data;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_BUSY;
            S_BUSY:  if (w_last)   w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = w_accept ? S_BUSY : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-channel step, sign correction and modulus validity
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            logic [MOD_W-1:0] w_m;
            logic [MOD_W-1:0] w_r;
            logic [MOD_W-1:0] w_step;
            logic [MOD_W-1:0] w_negr;
            logic             w_bad;

            assign w_m    = r_mod[i*MOD_W +: MOD_W];
            assign w_r    = r_acc[i*MOD_W +: MOD_W];
            assign w_bad  = (w_m < MOD_W'(2));
            assign w_negr = MOD_W'(res_neg(C_NEG_W'(w_m), C_NEG_W'(w_step)));

            rns_mod_step #(
                .MOD_W (MOD_W),
                .CHUNK (CHUNK)
            ) u_step (
                .r     (w_r),
                .chunk (r_mag[WIDTH-1 -: CHUNK]),
                .m     (w_m),
                .res   (w_step)
            );

            assign w_step_all[i*MOD_W +: MOD_W] = w_step;
            assign w_fin_all[i*MOD_W +: MOD_W]  = w_bad ? '0 : (r_neg ? w_negr : w_step);
            assign w_err[i]                     = w_bad;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Datapath: operand shift register, accumulators, counter, outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mag <= '0;
            r_neg <= 1'b0;
            r_mod <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_res <= '0;
            r_err <= '0;
        end else if (w_accept) begin
            r_mag <= w_mag_in;
            r_neg <= w_neg_in;
            r_mod <= moduli;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == S_BUSY) begin
            r_acc <= w_step_all;
            r_mag <= r_mag << CHUNK;
            r_cnt <= r_cnt + C_CNT_W'(1);
            // Results are written only on the final step so they stay
            // stable through DONE and through the next conversion.
            if (w_last) begin
                r_res <= w_fin_all;
                r_err <= w_err;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bin2rns_seq_conv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin2rns_seq_conv
//  Description : Self-checking bench for bin2rns_seq_conv. Expected residues
//                come from a '%'-based integer model and are queued on accept,
//                then compared when the converter hands a result over.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bin2rns_seq_conv;

    localparam int WIDTH  = 32;
    localparam int NCH    = 4;
    localparam int MOD_W  = 4;
    localparam int CHUNK  = 4;
    localparam int STEPS  = WIDTH / CHUNK;
    localparam int N_RAND = 2500;

    localparam logic [15:0] C_MOD_STD = {4'd3, 4'd5, 4'd7, 4'd8};
    localparam logic [15:0] C_MOD_BAD = {4'd3, 4'd0, 4'd1, 4'd8};

    typedef logic [NCH*MOD_W+NCH-1:0] exp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 in_signed;
    logic [NCH*MOD_W-1:0] moduli;
    logic                 out_valid;
    logic                 out_ready;
    logic [NCH*MOD_W-1:0] out_res;
    logic [NCH-1:0]       out_err;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    longint cyc      = 0;
    bit     rdone    = 1'b0;

    bin2rns_seq_conv #(
        .WIDTH (WIDTH),
        .NCH   (NCH),
        .MOD_W (MOD_W),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .moduli    (moduli),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic exp_t model(input logic [31:0] d, input logic s, input logic [15:0] m);
        logic [15:0] res;
        logic [3:0]  err;
        longint      v;
        longint      r;
        longint      mi;
        v = s ? longint'($signed(d)) : longint'(d);
        for (int i = 0; i < NCH; i++) begin
            mi = longint'(m[i*4 +: 4]);
            if (mi < 2) begin
                err[i]        = 1'b1;
                res[i*4 +: 4] = 4'd0;
            end else begin
                r = v % mi;
                if (r < 0) r = r + mi;
                err[i]        = 1'b0;
                res[i*4 +: 4] = r[3:0];
            end
        end
        return {err, res};
    endfunction

    // Call at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input logic [31:0] d, input logic s, input logic [15:0] m,
                        output longint acc);
        int guard;
        guard     = 0;
        in_data   = d;
        in_signed = s;
        moduli    = m;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check_eq("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            acc      = cyc;
            return;
        end
        @(posedge clk);
        sb.push_back(model(d, s, m));
        #1;
        acc       = cyc;
        in_valid  = 1'b0;
        in_data   = $urandom;
        in_signed = 1'($urandom);
        moduli    = 16'($urandom);
    endtask

    task automatic wait_out(input longint acc, output longint lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!out_valid) begin
            check_eq("out_timeout", 64'd0, 64'd1);
            lat = -1;
        end else begin
            lat = cyc - acc;
        end
    endtask

    task automatic run_one(input string tag, input logic [31:0] d, input logic s,
                           input logic [15:0] m);
        longint acc;
        longint lat;
        @(posedge clk);
        #1;
        send(d, s, m, acc);
        wait_out(acc, lat);
        check_eq(tag, 64'(lat), 64'(STEPS));
    endtask

    initial begin
        longint acc;
        longint lat;
        longint cb;
        int     guard;
        logic [15:0] snap_res;
        logic [3:0]  snap_err;
        logic [15:0] rm;
        logic [31:0] rd;
        exp_t        e;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_signed = 1'b0;
        moduli    = '0;
        out_ready = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (!reset && out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check_eq("sb_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("res", 64'(out_res), 64'(e[15:0]));
                        check_eq("err", 64'(out_err), 64'(e[19:16]));
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_res",   64'(out_res),   64'd0);
        check_eq("rst_err",   64'(out_err),   64'd0);
        check_eq("rst_ready", 64'(in_ready),  64'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("idle_ready", 64'(in_ready), 64'd1);

        // Directed conversions, consumer always ready
        run_one("lat_u100",  32'd100,        1'b0, C_MOD_STD);
        run_one("lat_sm1",   32'hFFFF_FFFF,  1'b1, C_MOD_STD);
        run_one("lat_um1",   32'hFFFF_FFFF,  1'b0, C_MOD_STD);
        run_one("lat_smin",  32'h8000_0000,  1'b1, C_MOD_STD);
        run_one("lat_s0",    32'd0,          1'b1, C_MOD_STD);

        // Backpressure then back-to-back accept
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(32'd1234, 1'b0, C_MOD_STD, acc);
        wait_out(acc, lat);
        check_eq("lat_bp", 64'(lat), 64'(STEPS));
        snap_res = out_res;
        snap_err = out_err;
        repeat (5) begin
            @(negedge clk);
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_out", 64'({out_err, out_res}), 64'({snap_err, snap_res}));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        cb        = cyc;
        send(32'hDEAD_BEEF, 1'b1, C_MOD_STD, acc);
        check_eq("b2b_accept", 64'(acc), 64'(cb + 1));
        @(negedge clk);
        check_eq("b2b_drop", 64'(out_valid), 64'd0);
        wait_out(acc, lat);
        check_eq("lat_b2b", 64'(lat), 64'(STEPS));

        // Invalid moduli
        run_one("lat_bad", 32'd100, 1'b0, C_MOD_BAD);

        // Reset mid-conversion at cnt=3
        @(posedge clk);
        #1;
        send(32'h0BAD_F00D, 1'b0, C_MOD_STD, acc);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        void'(sb.pop_back());
        #1;
        check_eq("abort_valid", 64'(out_valid), 64'd0);
        check_eq("abort_res",   64'(out_res),   64'd0);
        check_eq("abort_err",   64'(out_err),   64'd0);
        check_eq("abort_ready", 64'(in_ready),  64'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check_eq("abort_noout", 64'(out_valid), 64'd0);
        end
        run_one("lat_u35", 32'd35, 1'b0, C_MOD_STD);

        // Random operands, moduli, modes and stalls
        fork
            begin
                for (int n = 0; n < N_RAND; n++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    for (int i = 0; i < NCH; i++) rm[i*4 +: 4] = 4'($urandom_range(2, 15));
                    case ($urandom_range(0, 9))
                        0:       rd = 32'h8000_0000;
                        1:       rd = 32'hFFFF_FFFF;
                        2:       rd = 32'd0;
                        default: rd = $urandom;
                    endcase
                    send(rd, 1'($urandom), rm, acc);
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_eq("drain", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
